reg_cmd_decoder: RTL



---
 rtl/reg_cmd_decoder.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/reg_cmd_decoder.sv
// reg_cmd_decoder: command front-end for the 16-entry channel register block.
// Turns link command words into register strobes and one response per command.
module reg_cmd_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      rx_tdata,
    input  logic             rx_tvalid,
    output logic             rx_tready,
    output logic [31:0]      tx_tdata,
    output logic             tx_tvalid,
    input  logic             tx_tready,
    output logic [31:0]      reg_rx_data,
    output logic             reg_num_le,
    output logic             reg_wr_en,
    output logic             reg_rd_en,
    input  logic [31:0]      reg_tx_data,
    input  logic             illegal_reg_num,
    output logic [CNT_W-1:0] cmd_count,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [7:0]  OP_SEL   = 8'h01;
    localparam logic [7:0]  OP_WR    = 8'h02;
    localparam logic [7:0]  OP_RD    = 8'h03;
    localparam logic [7:0]  ST_OK    = 8'h00;
    localparam logic [7:0]  ST_ILL   = 8'h01;
    localparam logic [7:0]  ST_TMO   = 8'h02;
    localparam logic [7:0]  ST_UNK   = 8'h03;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_GET_SEL,
        S_LATCH,
        S_SEL_CHK,
        S_GET_WR,
        S_WR_DONE,
        S_RD_STROBE,
        S_RD_WAIT,
        S_SEND
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       op_q, op_d;
    logic [15:0]      tmo_q, tmo_d;
    logic             rx_tready_q, rx_tready_d;
    logic             tx_tvalid_q, tx_tvalid_d;
    logic [31:0]      tx_tdata_q, tx_tdata_d;
    logic [31:0]      reg_rx_data_q, reg_rx_data_d;
    logic             num_le_q, num_le_d;
    logic             wr_en_q, wr_en_d;
    logic             rd_en_q, rd_en_d;
    logic             resp_err_q, resp_err_d;
    logic [CNT_W-1:0] cmd_cnt_q, cmd_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic       rx_hs;
    logic       tx_hs;
    logic       tmo_hit;
    logic [7:0] rx_op;
    logic       rx_known;

    assign rx_hs    = rx_tvalid && rx_tready_q;
    assign tx_hs    = tx_tvalid_q && tx_tready;
    assign tmo_hit  = (tmo_q == TMO_LAST);
    assign rx_op    = rx_tdata[7:0];
    assign rx_known = (rx_op == OP_SEL) || (rx_op == OP_WR) || (rx_op == OP_RD);

    function automatic logic [31:0] status(input logic [7:0] op, input logic [7:0] code);
        return {16'hACC0, op, code};
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            op_q          <= '0;
            tmo_q         <= '0;
            rx_tready_q   <= 1'b0;
            tx_tvalid_q   <= 1'b0;
            tx_tdata_q    <= '0;
            reg_rx_data_q <= '0;
            num_le_q      <= 1'b0;
            wr_en_q       <= 1'b0;
            rd_en_q       <= 1'b0;
            resp_err_q    <= 1'b0;
            cmd_cnt_q     <= '0;
            err_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            tmo_q         <= tmo_d;
            rx_tready_q   <= rx_tready_d;
            tx_tvalid_q   <= tx_tvalid_d;
            tx_tdata_q    <= tx_tdata_d;
            reg_rx_data_q <= reg_rx_data_d;
            num_le_q      <= num_le_d;
            wr_en_q       <= wr_en_d;
            rd_en_q       <= rd_en_d;
            resp_err_q    <= resp_err_d;
            cmd_cnt_q     <= cmd_cnt_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (rx_hs) begin
                    if (rx_op == OP_SEL)     state_d = S_GET_SEL;
                    else if (rx_op == OP_WR) state_d = S_GET_WR;
                    else if (rx_op == OP_RD) state_d = S_RD_STROBE;
                    else                     state_d = S_SEND;
                end
            end
            S_GET_SEL: begin
                if (rx_hs)        state_d = S_LATCH;
                else if (tmo_hit) state_d = S_SEND;
            end
            S_LATCH:   state_d = S_SEL_CHK;
            S_SEL_CHK: state_d = S_SEND;
            S_GET_WR: begin
                if (rx_hs)        state_d = S_WR_DONE;
                else if (tmo_hit) state_d = S_SEND;
            end
            S_WR_DONE: state_d = S_SEND;
            // The read strobe was already decided at command accept.
            S_RD_STROBE: state_d = rd_en_q ? S_RD_WAIT : S_SEND;
            S_RD_WAIT:   state_d = S_SEND;
            S_SEND: begin
                if (tx_hs) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        op_d          = op_q;
        tmo_d         = tmo_q;
        tx_tdata_d    = tx_tdata_q;
        reg_rx_data_d = reg_rx_data_q;
        num_le_d      = 1'b0;
        wr_en_d       = 1'b0;
        rd_en_d       = 1'b0;
        resp_err_d    = resp_err_q;
        cmd_cnt_d     = cmd_cnt_q;
        err_cnt_d     = err_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (rx_hs) begin
                    op_d       = rx_op;
                    tmo_d      = '0;
                    resp_err_d = 1'b0;
                    if (rx_op == OP_RD) begin
                        rd_en_d = !illegal_reg_num;
                    end else if (!rx_known) begin
                        tx_tdata_d = status(rx_op, ST_UNK);
                        resp_err_d = 1'b1;
                    end
                end
            end
            S_GET_SEL, S_GET_WR: begin
                if (rx_hs) begin
                    if (state_q == S_GET_SEL) begin
                        reg_rx_data_d = rx_tdata;
                        num_le_d      = 1'b1;
                    end else if (!illegal_reg_num) begin
                        reg_rx_data_d = rx_tdata;
                        wr_en_d       = 1'b1;
                        tx_tdata_d    = status(op_q, ST_OK);
                    end else begin
                        tx_tdata_d = status(op_q, ST_ILL);
                        resp_err_d = 1'b1;
                    end
                end else if (tmo_hit) begin
                    tx_tdata_d = status(op_q, ST_TMO);
                    resp_err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            S_SEL_CHK: begin
                tx_tdata_d = status(op_q, illegal_reg_num ? ST_ILL : ST_OK);
                resp_err_d = illegal_reg_num;
            end
            S_RD_STROBE: begin
                if (!rd_en_q) begin
                    tx_tdata_d = status(op_q, ST_ILL);
                    resp_err_d = 1'b1;
                end
            end
            S_RD_WAIT: tx_tdata_d = reg_tx_data;
            S_SEND: begin
                if (tx_hs) begin
                    if (cmd_cnt_q != '1) cmd_cnt_d = cmd_cnt_q + CNT_W'(1);
                    if (resp_err_q && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_W'(1);
                end
            end
            default: begin
            end
        endcase
        rx_tready_d = (state_d == S_IDLE) || (state_d == S_GET_SEL) || (state_d == S_GET_WR);
        tx_tvalid_d = (state_d == S_SEND);
    end

    assign rx_tready   = rx_tready_q;
    assign tx_tvalid   = tx_tvalid_q;
    assign tx_tdata    = tx_tdata_q;
    assign reg_rx_data = reg_rx_data_q;
    assign reg_num_le  = num_le_q;
    assign reg_wr_en   = wr_en_q;
    assign reg_rd_en   = rd_en_q;
    assign cmd_count   = cmd_cnt_q;
    assign err_count   = err_cnt_q;

endmodule
